// File: rtl/binary_mul_pkg.sv
// Shared definitions for the 4x4 unsigned multiplier / accumulator path:
// default widths, accumulator width derivation and accumulator FSM encoding.
package binary_mul_pkg;

    localparam int P_W_DEF     = 8;
    localparam int ACC_LEN_DEF = 16;

    // Exact sum width: ACC_LEN products of P_W bits can never overflow it.
    function automatic int acc_w(input int p_w, input int acc_len);
        return p_w + $clog2(acc_len);
    endfunction

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } acc_state_t;

endpackage

// File: rtl/binary_mul_acc_uni_if.sv
// Product input and result output handshakes of the accumulate stage.
// master = surrounding datapath (upstream product source + downstream sink), slave = accumulator.
interface binary_mul_acc_uni_if
    import binary_mul_pkg::*;
#(
    parameter int P_W   = P_W_DEF,
    parameter int ACC_W = acc_w(P_W_DEF, ACC_LEN_DEF)
) ();

    logic [P_W-1:0]   p_in;
    logic             p_valid;
    logic             p_ready;
    logic [ACC_W-1:0] acc_out;
    logic             acc_valid;
    logic             acc_ready;

    modport master (
        output p_in, p_valid, acc_ready,
        input  p_ready, acc_out, acc_valid
    );

    modport slave (
        input  p_in, p_valid, acc_ready,
        output p_ready, acc_out, acc_valid
    );

endinterface

// File: rtl/binary_mul_acc_uni.sv
// Sums ACC_LEN consecutive accepted unsigned products into one result and
// presents it on a valid/ready output with backpressure.
module binary_mul_acc_uni
    import binary_mul_pkg::*;
#(
    parameter int P_W     = P_W_DEF,
    parameter int ACC_LEN = ACC_LEN_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       clr,
    binary_mul_acc_uni_if.slave        bus,
    output logic [$clog2(ACC_LEN)-1:0] cnt
);

    localparam int ACC_W = acc_w(P_W, ACC_LEN);
    localparam int CNT_W = $clog2(ACC_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_LEN - 1);

    acc_state_t       state;
    logic [ACC_W-1:0] sum;
    logic [ACC_W-1:0] sum_nxt;
    logic             accept;
    logic             last_accept;

    // acc_valid is a pure decode of the state register, so it is glitch-free.
    assign bus.acc_valid = (state == ST_HOLD);
    assign bus.p_ready   = en & (~bus.acc_valid | bus.acc_ready) & ~clr;

    assign accept      = bus.p_valid & bus.p_ready;
    assign last_accept = accept & (cnt == CNT_LAST);
    assign sum_nxt     = sum + ACC_W'(bus.p_in);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_ACCUM;
            sum         <= '0;
            cnt         <= '0;
            bus.acc_out <= '0;
        end else begin
            if (clr) begin
                sum <= '0;
                cnt <= '0;
            end else if (last_accept) begin
                sum         <= '0;
                cnt         <= '0;
                bus.acc_out <= sum_nxt;
            end else if (accept) begin
                sum <= sum_nxt;
                cnt <= cnt + 1'b1;
            end

            // In HOLD an accept implies acc_ready, so a final accept there is a back-to-back result.
            case (state)
                ST_ACCUM: if (last_accept)                  state <= ST_HOLD;
                ST_HOLD:  if (bus.acc_ready && !last_accept) state <= ST_ACCUM;
                default:                                     state <= ST_ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_binary_mul_acc_uni.sv
// Scoreboard bench for binary_mul_acc_uni: directed product streams, expected sums queued
// at issue time and compared by an independent output monitor.
module tb_binary_mul_acc_uni;
    import binary_mul_pkg::*;

    localparam int P_W     = 8;
    localparam int ACC_LEN = 16;
    localparam int ACC_W   = 12;
    localparam int CNT_W   = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic             clr;
    logic [CNT_W-1:0] cnt;

    binary_mul_acc_uni_if #(.P_W(P_W), .ACC_W(ACC_W)) bus_if ();

    binary_mul_acc_uni #(.P_W(P_W), .ACC_LEN(ACC_LEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .clr   (clr),
        .bus   (bus_if.slave),
        .cnt   (cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int sw_sum = 0;
    int sw_cnt = 0;
    int exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Output monitor: a handshake seen at the negedge completes at the next posedge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && bus_if.acc_valid && bus_if.acc_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", int'(bus_if.acc_out), -1);
                end else begin
                    check("acc_out", int'(bus_if.acc_out), exp_q.pop_front());
                end
            end
        end
    end

    // Offer one product and wait (bounded) until it is accepted; returns at posedge+1.
    task automatic send(input int p);
        int  n  = 0;
        bit  ok = 0;
        bus_if.p_valid = 1'b1;
        bus_if.p_in    = P_W'(p);
        while (n < 50) begin
            @(negedge clk);
            if (bus_if.p_ready) begin
                @(posedge clk); #1;
                ok = 1;
                break;
            end
            @(posedge clk); #1;
            n++;
        end
        bus_if.p_valid = 1'b0;
        if (!ok) begin
            check("send_timeout", n, 0);
        end else begin
            sw_sum += p;
            sw_cnt++;
            if (sw_cnt == ACC_LEN) begin
                exp_q.push_back(sw_sum);
                sw_sum = 0;
                sw_cnt = 0;
            end
            check("cnt_after_accept", int'(cnt), sw_cnt);
        end
    endtask

    task automatic clr_pulse();
        bus_if.p_valid = 1'b1;
        bus_if.p_in    = 8'd99;
        clr            = 1'b1;
        @(posedge clk); #1;
        clr            = 1'b0;
        bus_if.p_valid = 1'b0;
        sw_sum = 0;
        sw_cnt = 0;
        check("cnt_after_clr", int'(cnt), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time %0t limit reached", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        rst_n            = 1'b0;
        en               = 1'b1;
        clr              = 1'b0;
        bus_if.p_valid   = 1'b1;
        bus_if.p_in      = 8'd9;
        bus_if.acc_ready = 1'b1;

        // 1: reset holds everything empty even with a product offered
        repeat (3) @(posedge clk);
        #1;
        check("rst_acc_valid", int'(bus_if.acc_valid), 0);
        check("rst_acc_out", int'(bus_if.acc_out), 0);
        check("rst_cnt", int'(cnt), 0);
        bus_if.p_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(5);
        clr_pulse();

        // 2: full scale 16 x 225
        for (int i = 0; i < ACC_LEN; i++) send(225);
        check("full_acc_valid", int'(bus_if.acc_valid), 1);
        check("full_acc_out", int'(bus_if.acc_out), 3600);
        check("full_cnt", int'(cnt), 0);
        @(posedge clk); #1;
        check("full_valid_cleared", int'(bus_if.acc_valid), 0);

        // 3: backpressure holds result and blocks products
        bus_if.acc_ready = 1'b0;
        for (int i = 0; i < ACC_LEN; i++) send(225);
        bus_if.p_valid = 1'b1;
        bus_if.p_in    = 8'd7;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_p_ready", int'(bus_if.p_ready), 0);
            check("bp_acc_out", int'(bus_if.acc_out), 3600);
            check("bp_acc_valid", int'(bus_if.acc_valid), 1);
            check("bp_cnt", int'(cnt), 0);
            @(posedge clk); #1;
        end
        bus_if.p_valid   = 1'b0;
        bus_if.acc_ready = 1'b1;
        send(7);
        check("bp_resume_valid", int'(bus_if.acc_valid), 0);
        clr_pulse();

        // 4: continuous 0..15 twice, one accept per cycle, no stall
        c0 = cyc;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < ACC_LEN; i++) send(i);
        check("b2b_cycles", cyc - c0, 2 * ACC_LEN);
        check("b2b_queued_sum", exp_q[exp_q.size()-1], 120);

        // 5: clr mid-sequence discards partial sum
        for (int i = 0; i < 5; i++) send(10);
        clr_pulse();
        for (int i = 0; i < ACC_LEN; i++) send(1);
        check("clr_acc_out", int'(bus_if.acc_out), 16);
        repeat (2) @(posedge clk);
        #1;

        // 6: en gating, then async reset between edges at cnt=7
        for (int i = 0; i < 4; i++) send(3);
        en = 1'b0;
        bus_if.p_valid = 1'b1;
        bus_if.p_in    = 8'd3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("en_p_ready", int'(bus_if.p_ready), 0);
            @(posedge clk); #1;
            check("en_cnt", int'(cnt), 4);
        end
        bus_if.p_valid = 1'b0;
        en = 1'b1;
        for (int i = 0; i < 3; i++) send(3);
        check("pre_rst_cnt", int'(cnt), 7);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_cnt", int'(cnt), 0);
        check("async_rst_acc_out", int'(bus_if.acc_out), 0);
        check("async_rst_acc_valid", int'(bus_if.acc_valid), 0);
        sw_sum = 0;
        sw_cnt = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 7: all 256 multiplier pairs, row i sums to i*120
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) send(i * j);
            check("row_sum", int'(bus_if.acc_out), i * 120);
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
